ru_lsu: RTL and testbench

Load/store unit between the single-cycle core's memory stage and the word-addressed data RAM. It turns one core load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned RAM accesses. Sub-word stores use read-modify-write. Loads get byte/halfword extraction with sign or zero extension. The unit stalls the core until the access completes, honours the RAM `busy` handshake, and flags misaligned or illegal requests.

---
 rtl/ru_pkg.sv | 34 +++
 rtl/ru_lsu_align.sv | 58 +++++
 rtl/ru_lsu.sv | 100 ++++++++++
 tb/tb_ru_lsu.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ru_pkg.sv
// Shared types, funct3 encodings and request legality check for the load/store unit.
package ru_pkg;

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} lsu_state_t;

  typedef enum logic {LOAD, STORE} op_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // funct3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] lane);
    logic f3_ok;
    logic aligned;
    if (wr)
      f3_ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    else
      f3_ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    case (f3[1:0])
      2'b01:   aligned = !lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b1;
    endcase
    return !(rd && wr) && f3_ok && aligned;
  endfunction

endpackage

// File: rtl/ru_lsu_align.sv
// Byte-lane extraction with sign/zero extension for loads and lane merge for sub-word stores.
module ru_lsu_align
  import ru_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] ln,
                                          input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b  = 8'(word >> {ln, 3'b000});
    h  = 16'(word >> {ln[1], 4'b0000});
    bx = b;
    hx = h;
    case (f3)
      LB:      extract = bx;
      LH:      extract = hx;
      LBU:     extract = {24'h0, b};
      LHU:     extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  // Replicate the store data across all lanes, then let the mask pick the target lane.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [1:0] ln, input logic [2:0] f3);
    logic [31:0] mask;
    logic [31:0] rep;
    case (f3)
      SB: begin
        mask = 32'h0000_00FF << {ln, 3'b000};
        rep  = {4{wd[7:0]}};
      end
      SH: begin
        mask = 32'h0000_FFFF << {ln[1], 4'b0000};
        rep  = {2{wd[15:0]}};
      end
      default: begin
        mask = '1;
        rep  = wd;
      end
    endcase
    return (word & ~mask) | (rep & mask);
  endfunction

  assign ld_data = extract(ld_word, lane, funct3);
  assign st_data = merge(st_word, wdata, lane, funct3);

endmodule

// File: rtl/ru_lsu.sv
// Load/store unit: turns one core load/store into word-aligned RAM accesses, with RMW for SB/SH.
module ru_lsu
  import ru_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        fault,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_busy
);

  lsu_state_t  state;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rbuf;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic        req;

  assign req = mem_read | mem_write;

  ru_lsu_align u_align (
    .ld_word (ram_rdata),
    .st_word (rbuf),
    .wdata   (wdata_q),
    .lane    (addr_q[1:0]),
    .funct3  (f3_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  assign stall     = ((state == IDLE) && req) || (state == RD) || (state == WR);
  assign ram_we    = (state == WR) && !ram_busy;
  assign ram_wdata = (state == WR) ? st_data : '0;
  assign ram_addr  = (state == IDLE) ? {cpu_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      op_q      <= LOAD;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      rbuf      <= '0;
      cpu_rdata <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= cpu_addr;
            f3_q    <= funct3;
            wdata_q <= cpu_wdata;
            op_q    <= mem_write ? STORE : LOAD;
            if (!req_legal(mem_read, mem_write, funct3, cpu_addr[1:0])) begin
              state <= ERR;
              fault <= 1'b1;
            end else if (mem_write && (funct3 == SW)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (!ram_busy) begin
            rbuf <= ram_rdata;
            if (op_q == LOAD) begin
              cpu_rdata <= ld_data;
              state     <= DONE;
            end else begin
              state <= WR;
            end
          end
        end
        WR: begin
          if (!ram_busy)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ru_lsu.sv
// Self-checking bench for ru_lsu: transaction-level reference model plus directed literal checks.
module tb_ru_lsu;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        fault;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy = 1'b0;

  ru_lsu dut (
    .clk       (clk),
    .nRst      (nRst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .fault     (fault),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_busy  (ram_busy)
  );

  always #5 clk = ~clk;

  // RAM environment (64 words) and the reference copy the model updates per transaction
  logic [31:0] ram     [0:63];
  logic [31:0] ref_mem [0:63];

  assign ram_rdata = ram[ram_addr[7:2]];
  always @(posedge clk) if (ram_we) ram[ram_addr[7:2]] <= ram_wdata;

  int n_chk = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_fault, exp_we, exp_rd_chk;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [31:0] last_rd = '0;
  int          stall_cnt, we_cnt, fault_cnt, we_at, cur_k, consec;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("fault", 32'(fault), 32'(exp_fault));
      check("ram_we", 32'(ram_we), 32'(exp_we));
      check("ram_addr", ram_addr, exp_addr);
      if (exp_we) check("ram_wdata", ram_wdata, exp_wdata);
      if (exp_rd_chk) check("cpu_rdata", cpu_rdata, exp_rdata);
      if (stall) stall_cnt++;
      if (ram_we) begin
        we_cnt++;
        we_at = cur_k;
      end
      if (fault) fault_cnt++;
    end
  end

  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int size;
    if (rd && wr) return 1'b0;
    if (wr) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    end else begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    end
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [2:0] f3);
    int unsigned bv, hv;
    int v;
    bv = (w >> (8 * (a % 4))) % 256;
    hv = (w >> (16 * ((a % 4) / 2))) % 65536;
    case (f3)
      3'd0:    v = (bv >= 128) ? int'(bv) - 256 : int'(bv);
      3'd1:    v = (hv >= 32768) ? int'(hv) - 65536 : int'(hv);
      3'd4:    v = int'(bv);
      3'd5:    v = int'(hv);
      default: v = int'(w);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] by [4];
    int o;
    o = int'(a % 4);
    for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
    case (f3)
      3'd0: by[o] = d[7:0];
      3'd1: begin
        by[o]   = d[7:0];
        by[o+1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    endcase
    return {by[3], by[2], by[1], by[0]};
  endfunction

  function automatic bit pick_busy(input int k, input int busy_n, input bit rb);
    bit b;
    if (k < busy_n) b = 1'b1;
    else if (rb && consec < 3) b = ($urandom_range(0, 3) == 0);
    else b = 1'b0;
    consec = b ? consec + 1 : 0;
    return b;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction: issue cycle, each access phase (retried while busy), then DONE/ERR cycle.
  task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int busy_n, input bit rb);
    bit          legal, is_load, b;
    logic [31:0] old, nw;
    int          ph [2];
    int          nph, k;
    legal   = m_legal(rd, wr, f3, addr);
    is_load = rd && !wr;
    old     = ref_mem[addr[7:2]];
    nw      = m_store(old, wd, addr, f3);
    nph     = 0;
    ph[0]   = 0;
    ph[1]   = 0;
    if (legal) begin
      if (is_load) begin
        ph[0] = 1; nph = 1;
      end else if (f3 == 3'd2) begin
        ph[0] = 2; nph = 1;
      end else begin
        ph[0] = 1; ph[1] = 2; nph = 2;
      end
    end
    stall_cnt = 0; we_cnt = 0; fault_cnt = 0; we_at = -1; consec = 0; k = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
    cur_k = 0;
    ram_busy = pick_busy(k, busy_n, rb);
    exp_stall = 1'b1; exp_fault = 1'b0; exp_we = 1'b0; exp_wdata = nw;
    exp_addr = {addr[31:2], 2'b00}; exp_rd_chk = 1'b0; exp_rdata = last_rd;
    chk_en = 1'b1;
    next_cycle(); k++;
    for (int p = 0; p < nph; p++) begin
      for (int g = 0; g < 16; g++) begin
        cur_k = k;
        b = pick_busy(k, busy_n, rb);
        ram_busy = b;
        exp_stall = 1'b1;
        exp_we = (ph[p] == 2) && !b;
        next_cycle(); k++;
        if (!b) break;
      end
    end
    cur_k = k;
    ram_busy = pick_busy(k, busy_n, rb);
    if (legal && is_load) last_rd = m_load(old, addr, f3);
    if (legal && !is_load) ref_mem[addr[7:2]] = nw;
    exp_stall = 1'b0; exp_we = 1'b0; exp_fault = !legal;
    exp_rd_chk = 1'b1; exp_rdata = last_rd;
    next_cycle();
  endtask

  task automatic gap();
    mem_read = 1'b0; mem_write = 1'b0;
    cpu_addr = $urandom_range(0, 255); funct3 = 3'($urandom); cpu_wdata = $urandom;
    ram_busy = 1'($urandom_range(0, 1));
    cur_k = 0;
    exp_stall = 1'b0; exp_fault = 1'b0; exp_we = 1'b0;
    exp_addr = {cpu_addr[31:2], 2'b00}; exp_rd_chk = 1'b1; exp_rdata = last_rd;
    chk_en = 1'b1;
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  lf3 [5];
    logic [2:0]  f3;
    logic [31:0] a;
    bit          rd, wr;
    int          kind;
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[1] = 32'h11223344;
    ram[2] = 32'h80FF7F01;
    ram[4] = 32'h55667788;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    nRst = 1'b1;

    // Load extensions on 0x80FF7F01
    do_txn(1, 0, 3'd0, 32'h8, 32'h0, 0, 0);
    check("lb_8", cpu_rdata, 32'h00000001);
    check("lb_8_stall", 32'(stall_cnt), 32'd2);
    do_txn(1, 0, 3'd0, 32'hB, 32'h0, 0, 0);
    check("lb_b", cpu_rdata, 32'hFFFFFF80);
    check("lb_b_stall", 32'(stall_cnt), 32'd2);
    do_txn(1, 0, 3'd4, 32'hB, 32'h0, 0, 0);
    check("lbu_b", cpu_rdata, 32'h00000080);
    do_txn(1, 0, 3'd1, 32'hA, 32'h0, 0, 0);
    check("lh_a", cpu_rdata, 32'hFFFF80FF);
    do_txn(1, 0, 3'd5, 32'hA, 32'h0, 0, 0);
    check("lhu_a", cpu_rdata, 32'h000080FF);
    check("lhu_a_stall", 32'(stall_cnt), 32'd2);

    // SB read-modify-write
    do_txn(0, 1, 3'd0, 32'h6, 32'h000000AB, 0, 0);
    check("sb_word", ram[1], 32'h11AB3344);
    check("sb_we_cnt", 32'(we_cnt), 32'd1);
    check("sb_we_at", 32'(we_at), 32'd2);
    check("sb_stall", 32'(stall_cnt), 32'd3);

    // SW with RAM busy for the first three cycles
    do_txn(0, 1, 3'd2, 32'h20, 32'h0BADF00D, 3, 0);
    check("swb_stall", 32'(stall_cnt), 32'd4);
    check("swb_we_at", 32'(we_at), 32'd3);
    check("swb_we_cnt", 32'(we_cnt), 32'd1);
    check("swb_word", ram[8], 32'h0BADF00D);

    // Faults
    do_txn(1, 0, 3'd2, 32'h2, 32'h0, 0, 0);
    check("flt_lw2_fault", 32'(fault_cnt), 32'd1);
    check("flt_lw2_we", 32'(we_cnt), 32'd0);
    check("flt_lw2_stall", 32'(stall_cnt), 32'd1);
    do_txn(0, 1, 3'd1, 32'h5, 32'h00001234, 0, 0);
    check("flt_sh5_fault", 32'(fault_cnt), 32'd1);
    check("flt_sh5_we", 32'(we_cnt), 32'd0);
    check("flt_sh5_ram", ram[1], 32'h11AB3344);
    do_txn(1, 0, 3'd3, 32'h8, 32'h0, 0, 0);
    check("flt_f3_fault", 32'(fault_cnt), 32'd1);
    check("flt_f3_we", 32'(we_cnt), 32'd0);
    do_txn(1, 1, 3'd2, 32'h8, 32'hDEADBEEF, 0, 0);
    check("flt_rw_fault", 32'(fault_cnt), 32'd1);
    check("flt_rw_we", 32'(we_cnt), 32'd0);
    check("flt_rw_ram", ram[2], 32'h80FF7F01);
    check("flt_rdata_kept", cpu_rdata, 32'h000080FF);

    // Reset while an SB sits in WR
    gap();
    chk_en = 1'b0;
    mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'd0;
    cpu_addr = 32'h11; cpu_wdata = 32'h000000EE; ram_busy = 1'b0;
    next_cycle();
    next_cycle();
    check("rmw_wr_stall", 32'(stall), 32'h1);
    check("rmw_wr_wdata", ram_wdata, 32'h5566EE88);
    nRst = 1'b0; mem_write = 1'b0;
    #2;
    check("mid_rst_we", 32'(ram_we), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_fault", 32'(fault), 32'h0);
    check("mid_rst_wdata", ram_wdata, 32'h0);
    check("mid_rst_rdata", cpu_rdata, 32'h0);
    next_cycle();
    check("mid_rst_we2", 32'(ram_we), 32'h0);
    check("mid_rst_ram", ram[4], 32'h55667788);
    nRst = 1'b1;
    last_rd = '0;
    do_txn(1, 0, 3'd2, 32'h10, 32'h0, 0, 0);
    check("post_rst_lw", cpu_rdata, 32'h55667788);

    // Back-to-back SW then LW to the same word
    do_txn(0, 1, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0);
    do_txn(1, 0, 3'd2, 32'h0, 32'h0, 0, 0);
    check("b2b_lw", cpu_rdata, 32'hCAFEF00D);

    // Randomized traffic with random busy stretches
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 19);
      rd = (kind < 10) || (kind == 19);
      wr = (kind >= 10);
      if ($urandom_range(0, 4) != 0)
        f3 = (wr && !rd) ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      do_txn(rd, wr, f3, a, $urandom, 0, 1);
      if ($urandom_range(0, 2) == 0) gap();
    end
    gap();
    chk_en = 1'b0;

    for (int i = 0; i < 64; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
